uart_tx_fifo: RTL and testbench

UART_TX_FIFO -- requirements
Module: uart_tx_fifo

---
 rtl/uart_tx_fifo.sv | 202 ++++++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// UART transmitter with a transmit FIFO.
// A character is popped from the FIFO into the frame engine, together with a
// snapshot of the line settings. The frame engine then shifts out
// start / data (LSB first) / optional parity / 1 or 2 stop bits.
// txd is registered from the current state, so the line lags the state by one cycle.
module uart_tx_fifo #(
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned DIV_WIDTH  = 16
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic [DIV_WIDTH-1:0]          baud_div,
  input  logic                          parity_en,
  input  logic                          parity_odd,
  input  logic                          stop2,
  input  logic [DATA_BITS-1:0]          wr_data,
  input  logic                          wr_valid,
  output logic                          wr_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          busy,
  output logic                          frame_done,
  output logic                          txd
);

  localparam int unsigned PW  = $clog2(FIFO_DEPTH);
  localparam int unsigned CW  = PW + 1;
  localparam int unsigned BIW = $clog2(DATA_BITS);

  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

  // Reset release synchroniser and run qualifier
  logic [1:0]           r_rst_sync;
  logic                 w_run;

  // FIFO storage and bookkeeping
  logic [DATA_BITS-1:0] r_mem [FIFO_DEPTH];
  logic [PW-1:0]        r_wptr;
  logic [PW-1:0]        r_rptr;
  logic [CW-1:0]        r_count;
  logic                 w_full;
  logic                 w_push;
  logic                 w_pop;

  // Frame engine
  state_e               r_state;
  state_e               w_state_nxt;
  logic [DIV_WIDTH-1:0] r_baud_cnt;
  logic [DIV_WIDTH-1:0] r_div;
  logic                 r_par_en;
  logic                 r_par_odd;
  logic                 r_stop2;
  logic [DATA_BITS-1:0] r_data;
  logic [BIW-1:0]       r_bit_idx;
  logic                 r_stop_cnt;
  logic                 r_txd;
  logic                 r_frame_done;
  logic                 w_tick;
  logic                 w_done;
  logic                 w_txd;

  // Reset assertion is immediate; release ripples through two flops so the
  // core only starts accepting work once rstn has been seen high for two edges.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_rst_sync <= 2'b00;
    end else begin
      r_rst_sync <= {r_rst_sync[0], 1'b1};
    end
  end

  assign w_run = r_rst_sync[1];

  // Full is judged on the registered count only, so a same-cycle pop never
  // opens a slot for a push.
  assign w_full   = (r_count == CW'(FIFO_DEPTH));
  assign wr_ready = ~w_full;
  assign w_push   = wr_valid & ~w_full & w_run;

  // FIFO storage write port; contents need no reset since the count guards reads.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= wr_data;
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally at the power-of-2 depth.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PW'(1);
      if (w_pop)  r_rptr <= r_rptr + PW'(1);
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign w_tick = (r_baud_cnt == '0);

  // Next-state, pop request, end-of-frame strobe and line level for this state.
  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    w_done      = 1'b0;
    w_txd       = 1'b1;
    unique case (r_state)
      StIdle: begin
        if (w_run && (r_count != '0)) begin
          w_pop       = 1'b1;
          w_state_nxt = StStart;
        end
      end
      StStart: begin
        w_txd = 1'b0;
        if (w_tick) w_state_nxt = StData;
      end
      StData: begin
        w_txd = r_data[r_bit_idx];
        if (w_tick && (r_bit_idx == BIW'(DATA_BITS - 1))) begin
          w_state_nxt = r_par_en ? StParity : StStop;
        end
      end
      StParity: begin
        w_txd = (^r_data) ^ r_par_odd;
        if (w_tick) w_state_nxt = StStop;
      end
      StStop: begin
        w_txd = 1'b1;
        // Second stop bit only when two were requested and the first is done.
        if (w_tick && (!r_stop2 || r_stop_cnt)) begin
          w_done = 1'b1;
          if (r_count != '0) begin
            w_pop       = 1'b1;
            w_state_nxt = StStart;
          end else begin
            w_state_nxt = StIdle;
          end
        end
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Frame datapath: snapshot settings on pop, bit timer, bit and stop counters.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_baud_cnt <= '0;
      r_div      <= '0;
      r_par_en   <= 1'b0;
      r_par_odd  <= 1'b0;
      r_stop2    <= 1'b0;
      r_data     <= '0;
      r_bit_idx  <= '0;
      r_stop_cnt <= 1'b0;
    end else if (w_pop) begin
      r_baud_cnt <= baud_div;
      r_div      <= baud_div;
      r_par_en   <= parity_en;
      r_par_odd  <= parity_odd;
      r_stop2    <= stop2;
      r_data     <= r_mem[r_rptr];
      r_bit_idx  <= '0;
      r_stop_cnt <= 1'b0;
    end else if (r_state != StIdle) begin
      r_baud_cnt <= w_tick ? r_div : (r_baud_cnt - DIV_WIDTH'(1));
      if ((r_state == StData) && w_tick) r_bit_idx <= r_bit_idx + BIW'(1);
      if ((r_state == StStop) && w_tick) r_stop_cnt <= 1'b1;
    end
  end

  // Registered line and end-of-frame pulse, aligned with the last stop cycle on txd.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_txd        <= 1'b1;
      r_frame_done <= 1'b0;
    end else begin
      r_txd        <= w_txd;
      r_frame_done <= w_done;
    end
  end

  assign txd        = r_txd;
  assign frame_done = r_frame_done;
  assign fifo_count = r_count;
  assign busy       = (r_state != StIdle) | (r_count != '0);

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: an 8-bit/16-deep instance for most steps and
// a 7-bit/4-deep instance for the 7-bit parity + two-stop-bit frame.
module tb_uart_tx_fifo;

  logic        clk = 1'b0;
  logic        rstn;
  logic [15:0] baud_div;
  logic        parity_en, parity_odd, stop2;
  logic [7:0]  wr_data;
  logic        wr_valid, wr_ready;
  logic [4:0]  fifo_count;
  logic        busy, frame_done, txd;
  logic [6:0]  wr_data7;
  logic        wr_valid7, wr_ready7;
  logic [2:0]  fifo_count7;
  logic        busy7, frame_done7, txd7;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  uart_tx_fifo #(.DATA_BITS(8), .FIFO_DEPTH(16), .DIV_WIDTH(16)) dut (
    .clk(clk), .rstn(rstn), .baud_div(baud_div), .parity_en(parity_en),
    .parity_odd(parity_odd), .stop2(stop2), .wr_data(wr_data), .wr_valid(wr_valid),
    .wr_ready(wr_ready), .fifo_count(fifo_count), .busy(busy),
    .frame_done(frame_done), .txd(txd)
  );

  uart_tx_fifo #(.DATA_BITS(7), .FIFO_DEPTH(4), .DIV_WIDTH(16)) dut7 (
    .clk(clk), .rstn(rstn), .baud_div(baud_div), .parity_en(parity_en),
    .parity_odd(parity_odd), .stop2(stop2), .wr_data(wr_data7), .wr_valid(wr_valid7),
    .wr_ready(wr_ready7), .fifo_count(fifo_count7), .busy(busy7),
    .frame_done(frame_done7), .txd(txd7)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic push8(input logic [7:0] d);
    wr_data  = d;
    wr_valid = 1'b1;
    step();
    wr_valid = 1'b0;
  endtask

  function automatic logic cur_txd(input bit sel);
    return sel ? txd7 : txd;
  endfunction

  function automatic logic cur_fd(input bit sel);
    return sel ? frame_done7 : frame_done;
  endfunction

  // Waits for the start bit, then checks every cycle of the frame against the
  // expected line levels and frame_done only on the very last cycle.
  task automatic check_frame(input bit sel, input logic [8:0] data, input int nb,
                             input int div, input bit pe, input bit po, input bit s2,
                             input string tag, input bit chained);
    logic lv [16];
    int   n = 0;
    int   w = 0;
    bit   fd_ok = 1'b1;
    logic par;
    while ((cur_txd(sel) !== 1'b0) && (w < 3000)) begin
      step();
      w++;
    end
    chk({tag, "_start"}, (w < 3000), 1);
    if (chained) chk({tag, "_gap"}, w, 0);
    par = po;
    lv[n++] = 1'b0;
    for (int i = 0; i < nb; i++) begin
      lv[n++] = data[i];
      par = par ^ data[i];
    end
    if (pe) lv[n++] = par;
    lv[n++] = 1'b1;
    if (s2) lv[n++] = 1'b1;
    for (int b = 0; b < n; b++) begin
      logic bit_bad = 1'b0;
      logic seen    = 1'bx;
      for (int j = 0; j <= div; j++) begin
        if (cur_txd(sel) !== lv[b]) begin
          bit_bad = 1'b1;
          seen    = cur_txd(sel);
        end
        if (cur_fd(sel) !== ((b == n - 1) && (j == div))) fd_ok = 1'b0;
        step();
      end
      chk($sformatf("%s_bit%0d", tag, b), bit_bad ? seen : lv[b], lv[b]);
    end
    chk({tag, "_frame_done"}, fd_ok, 1);
  endtask

  initial begin
    begin : watchdog
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
    end
  end

  initial begin
    int resid;
    rstn       = 1'b0;
    baud_div   = 16'd3;
    parity_en  = 1'b0;
    parity_odd = 1'b0;
    stop2      = 1'b0;
    wr_data    = '0;
    wr_valid   = 1'b0;
    wr_data7   = '0;
    wr_valid7  = 1'b0;
    step();
    step();
    chk("rst_txd", txd, 1);
    chk("rst_wr_ready", wr_ready, 1);
    chk("rst_count", fifo_count, 0);
    chk("rst_busy", busy, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_txd7", txd7, 1);
    rstn = 1'b1;
    repeat (3) step();

    // Push into empty FIFO: pop one edge later, start bit one edge after that.
    push8(8'h55);
    chk("lat_n_count", fifo_count, 1);
    chk("lat_n_txd", txd, 1);
    step();
    chk("lat_n1_count", fifo_count, 0);
    chk("lat_n1_busy", busy, 1);
    chk("lat_n1_txd", txd, 1);
    step();
    chk("lat_n2_txd", txd, 0);
    check_frame(1'b0, 9'h055, 8, 3, 1'b0, 1'b0, 1'b0, "f55", 1'b0);
    chk("f55_idle_txd", txd, 1);
    chk("f55_idle_busy", busy, 0);

    // Divisor changed mid-frame only affects the following frame.
    push8(8'hC3);
    push8(8'h3A);
    baud_div = 16'd7;
    check_frame(1'b0, 9'h0C3, 8, 3, 1'b0, 1'b0, 1'b0, "fdivA", 1'b0);
    check_frame(1'b0, 9'h03A, 8, 7, 1'b0, 1'b0, 1'b0, "fdivB", 1'b1);
    chk("fdiv_idle_busy", busy, 0);

    // One clock per bit, odd parity.
    baud_div   = 16'd0;
    parity_en  = 1'b1;
    parity_odd = 1'b1;
    push8(8'hA3);
    check_frame(1'b0, 9'h0A3, 8, 0, 1'b1, 1'b1, 1'b0, "fodd", 1'b0);

    // Simultaneous push and pop at count 3.
    baud_div   = 16'd3;
    parity_en  = 1'b0;
    parity_odd = 1'b0;
    for (int k = 0; k < 4; k++) begin
      wr_data  = 8'h60 + 8'(k);
      wr_valid = 1'b1;
      step();
    end
    wr_valid = 1'b0;
    chk("pp_count3", fifo_count, 3);
    repeat (37) step();
    chk("pp_pre", fifo_count, 3);
    wr_data  = 8'h64;
    wr_valid = 1'b1;
    step();
    wr_valid = 1'b0;
    chk("pp_same", fifo_count, 3);
    chk("pp_done", frame_done, 1);
    for (int k = 1; k < 5; k++) begin
      check_frame(1'b0, {1'b0, 8'h60 + 8'(k)}, 8, 3, 1'b0, 1'b0, 1'b0,
                  $sformatf("fpp%0d", k), (k != 1));
    end

    // Fill to full while the first frame is in flight.
    for (int k = 0; k < 17; k++) begin
      wr_data  = 8'h80 + 8'(k);
      wr_valid = 1'b1;
      if (k == 0 || k == 16) chk($sformatf("full_rdy%0d", k), wr_ready, 1);
      step();
    end
    chk("full_count", fifo_count, 16);
    chk("full_ready", wr_ready, 0);
    wr_data = 8'hEE;
    repeat (24) step();
    chk("full_hold_count", fifo_count, 16);
    chk("full_hold_ready", wr_ready, 0);
    step();
    wr_valid = 1'b0;
    chk("full_pop_refused", fifo_count, 15);
    for (int k = 1; k < 17; k++) begin
      check_frame(1'b0, {1'b0, 8'h80 + 8'(k)}, 8, 3, 1'b0, 1'b0, 1'b0,
                  $sformatf("ffull%0d", k), (k != 1));
    end
    chk("ffull_idle_busy", busy, 0);

    // Reset during DATA with 5 entries queued.
    for (int k = 0; k < 6; k++) begin
      wr_data  = 8'hF0 + 8'(k);
      wr_valid = 1'b1;
      step();
    end
    wr_valid = 1'b0;
    repeat (6) step();
    chk("mid_count", fifo_count, 5);
    chk("mid_busy", busy, 1);
    #1 rstn = 1'b0;
    #1;
    chk("mid_rst_txd", txd, 1);
    chk("mid_rst_count", fifo_count, 0);
    chk("mid_rst_fd", frame_done, 0);
    chk("mid_rst_busy", busy, 0);
    step();
    step();
    rstn  = 1'b1;
    resid = 0;
    for (int i = 0; i < 150; i++) begin
      if ((txd !== 1'b1) || (frame_done !== 1'b0) || (fifo_count !== 5'd0)) resid++;
      step();
    end
    chk("mid_no_residual", resid, 0);

    // 7-bit character, even parity, two stop bits, two clocks per bit.
    baud_div   = 16'd1;
    parity_en  = 1'b1;
    parity_odd = 1'b0;
    stop2      = 1'b1;
    wr_data7   = 7'h07;
    wr_valid7  = 1'b1;
    step();
    wr_valid7  = 1'b0;
    check_frame(1'b1, 9'h007, 7, 1, 1'b1, 1'b0, 1'b1, "f7", 1'b0);
    chk("f7_idle_txd", txd7, 1);
    chk("f7_idle_busy", busy7, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
